// File: rtl/qupls4_ras_ctrl.sv
// Return-address stack predictor with optional pointer/count checkpoints.
// Checkpoint slots exist only when QUPLS4_RAS_CHKPT_EN is defined; otherwise chk_* inputs are ignored.
module qupls4_ras_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AWID  = 32,
  parameter int unsigned NCHK  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [AWID-1:0]            push_addr,
  input  logic                       pop,
  input  logic                       chk_save,
  input  logic                       chk_restore,
  input  logic [$clog2(NCHK)-1:0]    chk_id,
  output logic [AWID-1:0]            ret_addr,
  output logic                       ret_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AWID-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_tos;
  logic [CW-1:0]   r_count;
  logic [AWID-1:0] r_ret_addr;
  logic            r_ret_valid;
  logic            r_overflow;

  logic [PW-1:0]   w_tos_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_wr;
  logic [PW-1:0]   w_wr_idx;
  logic            w_pop_ok;
  logic            w_ovf;
  logic            w_full;
  logic            w_restore;
  logic [PW+CW-1:0] w_slot_val;

  assign w_full = (r_count == CW'(DEPTH));

`ifdef QUPLS4_RAS_CHKPT_EN
  logic [PW+CW-1:0] r_slot [NCHK];

  assign w_restore  = chk_restore;
  assign w_slot_val = r_slot[chk_id];

  // Save captures the post-update pointer/count; a simultaneous restore suppresses the save.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCHK; i++) r_slot[i] <= '0;
    end else if (en && chk_save && !chk_restore) begin
      r_slot[chk_id] <= {w_tos_nxt, w_cnt_nxt};
    end
  end
`else
  logic w_unused_chk;

  assign w_restore    = 1'b0;
  assign w_slot_val   = '0;
  assign w_unused_chk = ^{chk_save, chk_restore, chk_id};
`endif

  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_count;
    w_wr      = 1'b0;
    w_wr_idx  = r_tos;
    w_pop_ok  = 1'b0;
    w_ovf     = 1'b0;
    if (w_restore) begin
      {w_tos_nxt, w_cnt_nxt} = w_slot_val;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          w_tos_nxt = r_tos + 1'b1;
          w_wr      = 1'b1;
          w_wr_idx  = r_tos + 1'b1;
          if (w_full) w_ovf = 1'b1;
          else        w_cnt_nxt = r_count + 1'b1;
        end
        2'b01: begin
          if (r_count != '0) begin
            w_pop_ok  = 1'b1;
            w_tos_nxt = r_tos - 1'b1;
            w_cnt_nxt = r_count - 1'b1;
          end
        end
        2'b11: begin
          // Top is replaced in place; an empty stack just gains its first entry.
          w_wr = 1'b1;
          if (r_count == '0) w_cnt_nxt = CW'(1);
          else               w_pop_ok  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en && w_wr) r_mem[w_wr_idx] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos       <= '0;
      r_count     <= '0;
      r_ret_addr  <= '0;
      r_ret_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (en) begin
      r_tos       <= w_tos_nxt;
      r_count     <= w_cnt_nxt;
      r_ret_valid <= w_pop_ok;
      if (w_pop_ok) r_ret_addr <= r_mem[r_tos];
      if (w_ovf)    r_overflow <= 1'b1;
    end
  end

  assign ret_addr  = r_ret_addr;
  assign ret_valid = r_ret_valid;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_qupls4_ras_ctrl.sv
// Directed plus random bench for qupls4_ras_ctrl against a behavioural stack model.
module tb_qupls4_ras_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AWID  = 32;
  localparam int unsigned NCHK  = 4;

  logic             clk = 1'b0;
  logic             rst, en, push, pop, chk_save, chk_restore;
  logic [AWID-1:0]  push_addr;
  logic [1:0]       chk_id;
  logic [AWID-1:0]  ret_addr;
  logic             ret_valid;
  logic [4:0]       count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference state: circular array, pointer and count as plain integers.
  int unsigned m_mem [DEPTH];
  int          m_tos, m_cnt, m_rv, m_ov;
  int unsigned m_ra;
  int          s_tos [NCHK];
  int          s_cnt [NCHK];

  qupls4_ras_ctrl #(.DEPTH(DEPTH), .AWID(AWID), .NCHK(NCHK)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .push_addr(push_addr), .pop(pop),
    .chk_save(chk_save), .chk_restore(chk_restore), .chk_id(chk_id),
    .ret_addr(ret_addr), .ret_valid(ret_valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int nrv;
    bit rest;
    if (rst) begin
      m_tos = 0; m_cnt = 0; m_ra = 0; m_rv = 0; m_ov = 0;
      for (int i = 0; i < NCHK; i++) begin s_tos[i] = 0; s_cnt[i] = 0; end
      return;
    end
    if (!en) return;
`ifdef QUPLS4_RAS_CHKPT_EN
    rest = chk_restore;
`else
    rest = 1'b0;
`endif
    if (rest) begin
      m_tos = s_tos[chk_id]; m_cnt = s_cnt[chk_id]; m_rv = 0;
      return;
    end
    nrv = 0;
    if (push && !pop) begin
      m_tos = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = push_addr;
      if (m_cnt == DEPTH) m_ov = 1; else m_cnt++;
    end else if (pop && !push) begin
      if (m_cnt > 0) begin
        m_ra = m_mem[m_tos]; nrv = 1;
        m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--;
      end
    end else if (push && pop) begin
      if (m_cnt > 0) begin m_ra = m_mem[m_tos]; nrv = 1; end
      else m_cnt = 1;
      m_mem[m_tos] = push_addr;
    end
    m_rv = nrv;
`ifdef QUPLS4_RAS_CHKPT_EN
    if (chk_save) begin s_tos[chk_id] = m_tos; s_cnt[chk_id] = m_cnt; end
`endif
  endtask

  task automatic cyc(input bit r, input bit e, input bit pu, input int unsigned a,
                     input bit po, input bit sv, input bit rs, input int id);
    rst = r; en = e; push = pu; push_addr = a; pop = po;
    chk_save = sv; chk_restore = rs; chk_id = 2'(id);
    @(posedge clk);
    model_step();
    #1;
    chk("ret_valid", 64'(ret_valid), 64'(m_rv));
    chk("ret_addr",  64'(ret_addr),  64'(m_ra));
    chk("count",     64'(count),     64'(m_cnt));
    chk("overflow",  64'(overflow),  64'(m_ov));
    rst = 0; en = 1; push = 0; pop = 0; chk_save = 0; chk_restore = 0;
  endtask

  task automatic do_push(input int unsigned a); cyc(0, 1, 1, a, 0, 0, 0, 0); endtask
  task automatic do_pop();                      cyc(0, 1, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_rst();                      cyc(1, 1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    rst = 1; en = 1; push = 0; pop = 0; chk_save = 0; chk_restore = 0; chk_id = 0; push_addr = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    do_rst();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(ret_valid), 64'd0);
    chk("reset_addr",  64'(ret_addr), 64'd0);

    // Basic LIFO order
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("cnt3", 64'(count), 64'd3);
    do_pop(); chk("pop1", 64'(ret_addr), 64'h300); chk("pop1_v", 64'(ret_valid), 64'd1);
    do_pop(); chk("pop2", 64'(ret_addr), 64'h200);
    do_pop(); chk("pop3", 64'(ret_addr), 64'h100); chk("cnt0", 64'(count), 64'd0);

    // Underflow pop
    do_pop();
    chk("uf_valid", 64'(ret_valid), 64'd0);
    chk("uf_addr",  64'(ret_addr),  64'h100);
    chk("uf_count", 64'(count),     64'd0);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) do_push(32'h1000 + 4 * i);
    chk("of_count", 64'(count), 64'd16);
    chk("of_flag",  64'(overflow), 64'd1);
    for (int k = 0; k < 16; k++) begin
      do_pop();
      chk("of_pop", 64'(ret_addr), 64'(32'h1040 - 4 * k));
    end
    chk("of_empty", 64'(count), 64'd0);

    // Simultaneous push and pop replaces the top
    do_rst();
    chk("ovf_cleared", 64'(overflow), 64'd0);
    do_push(32'h100); do_push(32'h200);
    cyc(0, 1, 1, 32'h500, 1, 0, 0, 0);
    chk("pp_addr", 64'(ret_addr), 64'h200);
    chk("pp_cnt",  64'(count), 64'd2);
    do_pop();
    chk("pp_next", 64'(ret_addr), 64'h500);

    // Checkpoint save/restore
    do_rst();
    do_push(32'h100);
    cyc(0, 1, 0, 0, 0, 1, 0, 1);
    do_push(32'h200); do_push(32'h300);
    cyc(0, 1, 0, 0, 0, 0, 1, 1);
`ifdef QUPLS4_RAS_CHKPT_EN
    chk("ck_cnt", 64'(count), 64'd1);
    do_pop(); chk("ck_pop", 64'(ret_addr), 64'h100);
`else
    chk("ck_cnt", 64'(count), 64'd3);
    do_pop(); chk("ck_pop", 64'(ret_addr), 64'h300);
`endif

    // en=0 ignores push; reset during a pop cycle
    do_rst();
    do_push(32'h40);
    cyc(0, 0, 1, 32'h100, 0, 0, 0, 0);
    chk("en0_cnt", 64'(count), 64'd1);
    cyc(1, 1, 0, 0, 1, 0, 0, 0);
    chk("rst_pop_v",   64'(ret_valid), 64'd0);
    chk("rst_pop_cnt", 64'(count), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      bit pu, po, sv, rs, e, rr;
      r  = $urandom_range(0, 99);
      rr = (r == 0);
      e  = (r > 6);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 45);
      sv = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 11) == 0);
      if (rs) begin pu = 0; po = 0; end
      cyc(rr, e, pu, $urandom, po, sv, rs, int'($urandom_range(0, NCHK - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qupls4_ras_ctrl.md
QUPLS4_RAS_CTRL -- requirements
Module: Qupls4_ras_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, return-stack entries (power of two, 4..64).
REQ-002 Parameter AWID, default 32, return-address width in bits.
REQ-003 Parameter NCHK, default 4, number of checkpoint slots (power of two).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  pipeline advance; when low, no state changes and outputs hold.
REQ-007 push  input  1  decoded call (BSR, JSR or JSRN) valid this cycle.
REQ-008 push_addr  input  AWID  return address for the call (call pc + length).
REQ-009 pop  input  1  decoded return instruction valid this cycle.
REQ-010 chk_save  input  1  save current pointer/count into slot chk_id.
REQ-011 chk_restore  input  1  restore pointer/count from slot chk_id (branch miss).
REQ-012 chk_id  input  $clog2(NCHK)  checkpoint slot select.
REQ-013 ret_addr  output  AWID  predicted return address, registered.
REQ-014 ret_valid  output  1  ret_addr valid; one-cycle pulse per accepted pop.
REQ-015 count  output  $clog2(DEPTH)+1  live entries, 0..DEPTH.
REQ-016 overflow  output  1  sticky; set when a push overwrites the oldest entry.

Function
REQ-017 Circular array of DEPTH entries; tos pointer addresses the top entry.
REQ-018 Push only (en=1): tos <= tos+1 mod DEPTH; mem[tos+1] <= push_addr; count saturates at DEPTH.
REQ-019 Push when count==DEPTH: oldest entry overwritten, count stays DEPTH, overflow set.
REQ-020 Pop only, count>0: ret_addr <= mem[tos], ret_valid=1 next cycle, tos <= tos-1 mod DEPTH, count-1.
REQ-021 Pop with count==0: ret_valid=0 next cycle, ret_addr holds, tos and count unchanged.
REQ-022 Push and pop same cycle: ret_addr <= mem[tos] (old top), mem[tos] <= push_addr, tos and count unchanged; ret_valid=1 only if count>0 (if count==0, entry written, count becomes 1).
REQ-023 Latency: ret_addr/ret_valid registered, exactly one cycle after the pop cycle.
REQ-024 ret_valid deasserts in any cycle with no accepted pop.
REQ-025 chk_save: slot[chk_id] <= {tos, count} as they stand after the same cycle's push/pop.
REQ-026 chk_restore: tos, count <= slot[chk_id]; overrides any push/pop that cycle; ret_valid=0 next cycle.
REQ-027 chk_save and chk_restore same cycle: restore wins, slot unchanged.
REQ-028 Restore does not modify mem contents; overflow unaffected.
REQ-029 en=0 ignores push, pop, chk_save, chk_restore.

Reset
REQ-030 On rst: tos=0, count=0, ret_addr=0, ret_valid=0, overflow=0, all checkpoint slots {0,0}.
REQ-031 rst overrides en and all requests; mem contents need not be cleared.
REQ-032 rst asserted mid-sequence: next cycle outputs are reset values and count=0.

Configuration
REQ-033 Macro QUPLS4_RAS_CHKPT_EN: when defined, checkpoint slots and chk_save/chk_restore behave per REQ-025..028.
REQ-034 Without QUPLS4_RAS_CHKPT_EN: ports remain, inputs ignored, no slot storage synthesized; all other behaviour identical.

Verification
REQ-035 Reset, push 0x100,0x200,0x300, pop x3 -> ret_addr 0x300,0x200,0x100 each one cycle after pop, count 3->0.
REQ-036 Pop with count==0 -> ret_valid=0, ret_addr unchanged, count stays 0.
REQ-037 DEPTH=16: push 17 addresses 0x1000+4i -> count=16, overflow=1; 16 pops return 0x1040 down to 0x1004.
REQ-038 count=2 (top 0x200), push 0x500+pop same cycle -> ret_addr=0x200, count=2, next pop returns 0x500.
REQ-039 Push 0x100, chk_save id 1, push 0x200,0x300, chk_restore id 1 -> count=1, next pop returns 0x100 (macro defined); macro undefined -> count=3, pop returns 0x300.
REQ-040 Push 0x100 with en=0 -> count unchanged; rst during pop cycle -> ret_valid=0, count=0 next cycle.
